// File: rtl/vga_fb_scanout.sv
// ---------------------------------------------------------------------------
// vga_fb_scanout
//
// Takes the pixel-write stream from the game draw logic and stores it in an
// on-chip 1-bit framebuffer. The framebuffer is scanned out continuously as
// VGA (640x480 with the default timing parameters), with sync, blank and RGB
// outputs.
//
// Scan pipeline (all stages advance on the pixel tick pe):
//   counters -> stage 0 : read address computed from hc/vc, RAM read on pe
//            -> stage 1 : RAM data + visible/hs/vs registered
//            -> stage 2 : output registers
// All video outputs therefore lag the counters by exactly two pixel ticks.
// frame_start is aligned to the counters, not to the delayed outputs.
//
// Ports:
//   clk          system clock (only clock)
//   reset        synchronous, active-high
//   wr_en        write strobe, one pixel per clk while high
//   wr_x, wr_y   write coordinate; out-of-range writes are dropped
//   wr_color     pixel value to store
//   vga_hs       horizontal sync, active low
//   vga_vs       vertical sync, active low
//   vga_blank_n  high during the visible region
//   vga_r/g/b    pixel colour, 8 bits each
//   frame_start  one-clk pulse on the counter wrap (last pixel -> 0,0)
//
// Optional feature, macro VGA_FB_DOUBLE_BUFFER_EN:
//   swap_req     (in)  request a buffer swap; latched until the next frame
//   disp_sel     (out) buffer currently scanned out; writes go to the other
// ---------------------------------------------------------------------------
module vga_fb_scanout #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          CLK_DIV  = 2,
  parameter logic [23:0] FG_RGB   = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB   = 24'h000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [9:0] wr_x,
  input  logic [8:0] wr_y,
  input  logic       wr_color,
`ifdef VGA_FB_DOUBLE_BUFFER_EN
  input  logic       swap_req,
  output logic       disp_sel,
`endif
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_start
);

  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W   = $clog2(FB_DEPTH);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]       H_LAST   = 10'(HT - 1);
  localparam logic [9:0]       V_LAST   = 10'(VT - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]       HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]       VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // timing counters
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hc_q, hc_d;
  logic [9:0]       vc_q, vc_d;
  logic             pe;
  logic             line_end;
  logic             frame_end;

  // stage 0 (combinational from counters)
  logic              vis0;
  logic              hs0;
  logic              vs0;
  logic [ADDR_W-1:0] rd_addr;

  // stage 1
  logic vis1_q, vis1_d;
  logic hs1_q,  hs1_d;
  logic vs1_q,  vs1_d;
  logic fb_rdata_q;

  // stage 2 (outputs)
  logic        blank_n_q, blank_n_d;
  logic        hs_q,      hs_d;
  logic        vs_q,      vs_d;
  logic [23:0] rgb_q,     rgb_d;

  // write port
  logic              wr_ok;
  logic [ADDR_W-1:0] wr_addr;

  // -------------------------------------------------------------------------
  // Pixel tick and raster counters
  // -------------------------------------------------------------------------
  always_comb begin
    div_d = div_q;
    hc_d  = hc_q;
    vc_d  = vc_q;

    // Divider resets to 0, so the first tick lands CLK_DIV clks after release.
    pe        = (div_q == DIV_LAST);
    line_end  = (hc_q == H_LAST);
    frame_end = line_end && (vc_q == V_LAST);

    if (pe) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (pe) begin
      if (line_end) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end

    frame_start = pe && frame_end;
  end

  // -------------------------------------------------------------------------
  // Stage 0: address and raw sync levels from the current counters
  // -------------------------------------------------------------------------
  always_comb begin
    vis0 = (hc_q < H_VIS) && (vc_q < V_VIS);
    hs0  = !((hc_q >= HS_START) && (hc_q < HS_END));
    vs0  = !((vc_q >= VS_START) && (vc_q < VS_END));
    // Blanking reads park on address 0; the cleared visible flag masks it.
    rd_addr = vis0 ? (ADDR_W'(vc_q) * ADDR_W'(H_ACTIVE) + ADDR_W'(hc_q))
                   : '0;
  end

  // -------------------------------------------------------------------------
  // Stage 1 / stage 2 next-state
  // -------------------------------------------------------------------------
  always_comb begin
    vis1_d    = vis1_q;
    hs1_d     = hs1_q;
    vs1_d     = vs1_q;
    blank_n_d = blank_n_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    rgb_d     = rgb_q;

    if (pe) begin
      vis1_d    = vis0;
      hs1_d     = hs0;
      vs1_d     = vs0;
      blank_n_d = vis1_q;
      hs_d      = hs1_q;
      vs_d      = vs1_q;
      if (vis1_q) begin
        rgb_d = fb_rdata_q ? FG_RGB : BG_RGB;
      end else begin
        rgb_d = 24'h000000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      hc_q      <= '0;
      vc_q      <= '0;
      vis1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      blank_n_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rgb_q     <= 24'h000000;
    end else begin
      div_q     <= div_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      vis1_q    <= vis1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      blank_n_q <= blank_n_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      rgb_q     <= rgb_d;
    end
  end

  // -------------------------------------------------------------------------
  // Write port decode (independent of the pixel tick)
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ok   = wr_en && (wr_x < H_VIS) && ({1'b0, wr_y} < V_VIS);
    wr_addr = ADDR_W'(wr_y) * ADDR_W'(H_ACTIVE) + ADDR_W'(wr_x);
  end

  // -------------------------------------------------------------------------
  // Framebuffer storage. Read-before-write: a write to the address being
  // scanned in the same clk shows up on the next frame. Contents are not
  // reset.
  // -------------------------------------------------------------------------
`ifdef VGA_FB_DOUBLE_BUFFER_EN
  logic disp_sel_q, disp_sel_d;
  logic swap_pend_q, swap_pend_d;
  logic swap_now;
  logic fb0_mem [FB_DEPTH];
  logic fb1_mem [FB_DEPTH];

  // A request arriving on the frame_start clk itself swaps at that boundary.
  always_comb begin
    swap_now    = frame_start && (swap_pend_q || swap_req);
    disp_sel_d  = disp_sel_q ^ swap_now;
    swap_pend_d = swap_now ? 1'b0 : (swap_pend_q || swap_req);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_sel_q  <= 1'b0;
      swap_pend_q <= 1'b0;
    end else begin
      disp_sel_q  <= disp_sel_d;
      swap_pend_q <= swap_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (disp_sel_q) begin
        fb0_mem[wr_addr] <= wr_color;
      end else begin
        fb1_mem[wr_addr] <= wr_color;
      end
    end
    if (pe) begin
      fb_rdata_q <= disp_sel_q ? fb1_mem[rd_addr] : fb0_mem[rd_addr];
    end
  end

  assign disp_sel = disp_sel_q;
`else
  logic fb_mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      fb_mem[wr_addr] <= wr_color;
    end
    if (pe) begin
      fb_rdata_q <= fb_mem[rd_addr];
    end
  end
`endif

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout. A shrunken raster (16x8 visible, 24x12 total,
// CLK_DIV=2, frame = 576 clk) carries the pixel, sync and frame checks; a
// default-parameter instance checks the real 640x480 hsync timing.
//
// Timeline reference: cyc counts posedges since reset release. Counter tick t
// holds during cyc 2t..2t+1, and the output for tick t is visible during
// cyc 2t+4..2t+5 (two pixel ticks of lag).
module tb_vga_fb_scanout;

  localparam int S_HT    = 24;
  localparam int S_FRAME = 24 * 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [9:0] wr_x = '0;
  logic [8:0] wr_y = '0;
  logic       wr_color = 1'b0;
  logic       f_wr_en = 1'b0;

  logic       hs, vs, blank_n, fs;
  logic [7:0] r, g, b;
  logic       f_hs, f_vs, f_blank_n, f_fs;
  logic [7:0] f_r, f_g, f_b;

`ifdef VGA_FB_DOUBLE_BUFFER_EN
  logic swap_req = 1'b0;
  logic f_swap_req = 1'b0;
  logic disp_sel, f_disp_sel;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  vga_fb_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2)
  ) dut_s (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    .swap_req(swap_req), .disp_sel(disp_sel),
`endif
    .vga_hs(hs), .vga_vs(vs), .vga_blank_n(blank_n),
    .vga_r(r), .vga_g(g), .vga_b(b), .frame_start(fs)
  );

  vga_fb_scanout dut_f (
    .clk(clk), .reset(reset),
    .wr_en(f_wr_en), .wr_x(10'd0), .wr_y(9'd0), .wr_color(1'b0),
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    .swap_req(f_swap_req), .disp_sel(f_disp_sel),
`endif
    .vga_hs(f_hs), .vga_vs(f_vs), .vga_blank_n(f_blank_n),
    .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .frame_start(f_fs)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) check_eq("timeline", cyc, c);
  endtask

  function automatic int pix(input int f, input int x, input int y);
    return f * S_FRAME + y * S_HT + x;
  endfunction

  task automatic goto_pix(input int t);
    goto_cyc(2 * t + 4);
  endtask

  task automatic check_pix(input string tag, input int t,
                           input logic [23:0] rgb, input logic bl);
    goto_pix(t);
    check_eq({tag, "_rgb"}, {8'h0, r, g, b}, {8'h0, rgb});
    check_eq({tag, "_blank"}, {31'h0, blank_n}, {31'h0, bl});
  endtask

  task automatic write_px(input int x, input int y, input logic c);
    wr_en    = 1'b1;
    wr_x     = 10'(x);
    wr_y     = 9'(y);
    wr_color = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_hs"},    {31'h0, hs},      32'h1);
    check_eq({tag, "_vs"},    {31'h0, vs},      32'h1);
    check_eq({tag, "_blank"}, {31'h0, blank_n}, 32'h0);
    check_eq({tag, "_rgb"},   {8'h0, r, g, b},  32'h0);
    check_eq({tag, "_fs"},    {31'h0, fs},      32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("rst");

    // Clear the framebuffer (writes are accepted while in reset), then the
    // pattern plus two out-of-range writes that must be dropped.
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++)
        write_px(x, y, 1'b0);
    write_px(0, 0, 1'b1);
    write_px(15, 7, 1'b1);
    write_px(3, 3, 1'b1);
    write_px(16, 3, 1'b1);   // would alias (0,4) if not dropped
    write_px(5, 8, 1'b1);    // would alias (5,0) if not dropped
    reset = 1'b0;

`ifdef VGA_FB_DOUBLE_BUFFER_EN
    goto_cyc(200);
    check_eq("db_sel0", {31'h0, disp_sel}, 32'h0);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    goto_cyc(574);
    check_eq("db_sel_pre", {31'h0, disp_sel}, 32'h0);
    goto_cyc(575);
    check_eq("db_fs", {31'h0, fs}, 32'h1);
    goto_cyc(576);
    check_eq("db_sel_swap", {31'h0, disp_sel}, 32'h1);
    check_pix("db_p00", pix(1, 0, 0), 24'hFFFFFF, 1'b1);
    check_pix("db_p10", pix(1, 1, 0), 24'h000000, 1'b1);
    check_pix("db_p50", pix(1, 5, 0), 24'h000000, 1'b1);
    check_pix("db_p33", pix(1, 3, 3), 24'hFFFFFF, 1'b1);
    goto_cyc(1151);
    check_eq("db_sel_hold", {31'h0, disp_sel}, 32'h1);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    check_eq("db_sel_coinc", {31'h0, disp_sel}, 32'h0);
`else
    goto_cyc(3);
    check_eq("lat_rgb", {8'h0, r, g, b}, 32'h0);
    check_pix("p00", pix(0, 0, 0), 24'hFFFFFF, 1'b1);
    check_pix("p10", pix(0, 1, 0), 24'h000000, 1'b1);
    check_pix("p50", pix(0, 5, 0), 24'h000000, 1'b1);
    check_pix("p150", pix(0, 15, 0), 24'h000000, 1'b1);
    check_pix("p160", pix(0, 16, 0), 24'h000000, 1'b0);
    goto_pix(pix(0, 17, 0)); check_eq("hs17", {31'h0, hs}, 32'h1);
    goto_pix(pix(0, 18, 0)); check_eq("hs18", {31'h0, hs}, 32'h0);
    goto_pix(pix(0, 21, 0)); check_eq("hs21", {31'h0, hs}, 32'h0);
    goto_pix(pix(0, 22, 0)); check_eq("hs22", {31'h0, hs}, 32'h1);

    // Write (10,2) on the clk whose pe edge reads (10,2).
    goto_cyc(2 * pix(0, 10, 2) + 1);
    write_px(10, 2, 1'b1);
    check_pix("same_f0", pix(0, 10, 2), 24'h000000, 1'b1);
    check_pix("p33", pix(0, 3, 3), 24'hFFFFFF, 1'b1);
    check_pix("p04", pix(0, 0, 4), 24'h000000, 1'b1);
    check_pix("p157", pix(0, 15, 7), 24'hFFFFFF, 1'b1);
    check_pix("p08", pix(0, 0, 8), 24'h000000, 1'b0);
    check_eq("vs8", {31'h0, vs}, 32'h1);
    goto_pix(pix(0, 0, 9));  check_eq("vs9",  {31'h0, vs}, 32'h0);
    goto_pix(pix(0, 0, 10)); check_eq("vs10", {31'h0, vs}, 32'h0);
    goto_pix(pix(0, 0, 11)); check_eq("vs11", {31'h0, vs}, 32'h1);
    goto_cyc(574); check_eq("fs574", {31'h0, fs}, 32'h0);
    goto_cyc(575); check_eq("fs575", {31'h0, fs}, 32'h1);
    goto_cyc(576); check_eq("fs576", {31'h0, fs}, 32'h0);
    check_pix("f1_p00", pix(1, 0, 0), 24'hFFFFFF, 1'b1);
    check_pix("same_f1", pix(1, 10, 2), 24'hFFFFFF, 1'b1);
    goto_cyc(1151); check_eq("fs1151", {31'h0, fs}, 32'h1);

    // Reset while counters sit at (5,3) of frame 2; output shows (3,3).
    goto_cyc(2 * pix(2, 5, 3));
    check_eq("pre_rst_blank", {31'h0, blank_n}, 32'h1);
    check_eq("pre_rst_rgb", {8'h0, r, g, b}, 32'hFFFFFF);
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid_rst");
    check_eq("mid_rst_hc", {22'h0, dut_s.hc_q}, 32'h0);
    check_eq("mid_rst_vc", {22'h0, dut_s.vc_q}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check_pix("r_p00", pix(0, 0, 0), 24'hFFFFFF, 1'b1);
    check_pix("r_p102", pix(0, 10, 2), 24'hFFFFFF, 1'b1);
    check_pix("r_p33", pix(0, 3, 3), 24'hFFFFFF, 1'b1);
    check_pix("r_p157", pix(0, 15, 7), 24'hFFFFFF, 1'b1);
    goto_cyc(575); check_eq("r_fs575", {31'h0, fs}, 32'h1);
`endif

    // Full 640x480 timing: hsync low for hc 656..751 (192 clk), line 1600 clk.
    goto_cyc(1315); check_eq("f_hs1315", {31'h0, f_hs}, 32'h1);
    goto_cyc(1316); check_eq("f_hs1316", {31'h0, f_hs}, 32'h0);
    goto_cyc(1507); check_eq("f_hs1507", {31'h0, f_hs}, 32'h0);
    goto_cyc(1508); check_eq("f_hs1508", {31'h0, f_hs}, 32'h1);
    goto_cyc(2915); check_eq("f_hs2915", {31'h0, f_hs}, 32'h1);
    goto_cyc(2916); check_eq("f_hs2916", {31'h0, f_hs}, 32'h0);
    check_eq("f_vs_line1", {31'h0, f_vs}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
